text_scanout: RTL

TEXT_SCANOUT -- requirements
Module: text_scanout

---
 rtl/text_scanout_pkg.sv | 34 +++
 rtl/text_scanout_font_rom.sv | 27 ++
 rtl/text_scanout.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/text_scanout_pkg.sv
// Shared VGA 640x480 timing constants, colour type and the 8x8 glyph table.
// Latency: n/a (constants and a pure function).
// Backpressure: n/a.
package text_scanout_pkg;

   localparam int H_ACTIVE = 640;
   localparam int H_TOTAL  = 800;
   localparam int HS_START = 656;
   localparam int HS_END   = 751;
   localparam int V_ACTIVE = 480;
   localparam int V_TOTAL  = 525;
   localparam int VS_START = 490;
   localparam int VS_END   = 491;
   localparam int PIPE_LAT = 3;

   typedef logic [2:0] rgb3_t;

   // One 8-pixel glyph row; row 0 is the top line, bit 7 the leftmost pixel.
   // Codes without a glyph render blank.
   function automatic logic [7:0] font_row(input logic [7:0] code, input logic [2:0] row);
      logic [63:0] g;
      logic [5:0]  sh;
      case (code)
         8'h41:   g = 64'h183C_6666_7E66_6600;  // 'A'
         8'h42:   g = 64'h7C66_667C_6666_7C00;  // 'B'
         8'h48:   g = 64'h6666_667E_6666_6600;  // 'H'
         8'h49:   g = 64'h3C18_1818_1818_3C00;  // 'I'
         default: g = 64'h0;
      endcase
      sh = {3'd7 - row, 3'b000};
      return 8'(g >> sh);
   endfunction

endpackage

// File: rtl/text_scanout_font_rom.sv
// 2048x8 character generator ROM addressed by {char, glyph row}.
// Latency: 1 cycle, data register updates only when en_i is high.
// Backpressure: none, accepts one read per cycle.
module text_font_rom
   import text_scanout_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        en_i,
   input  logic [10:0] addr_i,
   output logic [7:0]  data_o
);

   logic [7:0] data_q;

   // Synchronous read; output holds between reads.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         data_q <= '0;
      end else if (en_i) begin
         data_q <= font_row(addr_i[10:3], addr_i[2:0]);
      end
   end

   assign data_o = data_q;

endmodule

// File: rtl/text_scanout.sv
// 80x60 text-mode scan-out on a 640x480 raster; optional blink via TEXT_SCANOUT_BLINK_EN.
// Latency: video outputs lag the raster counters by 3 cycles (fetch, font, shift).
// Backpressure: none; display memory must answer every read on the next cycle.
module text_scanout
   import text_scanout_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR = 16'd895,
   parameter int          COLS      = 80
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [15:0] mem_addr,
   output logic        mem_rd_en,
   input  logic [15:0] mem_rd_data,
   output logic        hsync,
   output logic        vsync,
   output logic        de,
   output logic [2:0]  rgb,
   output logic        frame_start
);

   // Raster counters; run_q holds them at 0 for one edge after reset so
   // the first counted cycle is a genuine frame start.
   logic        run_q;
   logic [9:0]  h_q, h_d, v_q, v_d;
   logic        act0, hs0, vs0, fetch_d;
   logic [15:0] addr_d;
   logic        mem_rd_en_q, frame_start_q;
   logic [15:0] mem_addr_q;
   // FONT stage
   logic        rd_p1_q, act_p1_q, hs_p1_q, vs_p1_q;
   logic [2:0]  hlo_p1_q, vlo_p1_q;
   rgb3_t       fg_q, bg_q;
   logic [7:0]  rom_dout;
   // SHIFT stage
   logic        act_p2_q, hs_p2_q, vs_p2_q;
   logic [2:0]  hlo_p2_q;
   logic [7:0]  row_q, row_sel;
   logic        pix;
   rgb3_t       fg_eff;
   // Output registers
   logic        de_q, hsync_q, vsync_q;
   rgb3_t       rgb_q;
   logic        unused_bits;

   // Next raster position; wraps line then frame in the same cycle.
   always_comb begin
      h_d = h_q;
      v_d = v_q;
      if (run_q) begin
         if (h_q == 10'(H_TOTAL - 1)) begin
            h_d = '0;
            v_d = (v_q == 10'(V_TOTAL - 1)) ? '0 : v_q + 10'd1;
         end else begin
            h_d = h_q + 10'd1;
         end
      end
   end

   assign act0    = run_q && (h_q < 10'(H_ACTIVE)) && (v_q < 10'(V_ACTIVE));
   assign hs0     = run_q && (h_q >= 10'(HS_START)) && (h_q <= 10'(HS_END));
   assign vs0     = run_q && (v_q >= 10'(VS_START)) && (v_q <= 10'(VS_END));
   // Fetch strobe and frame marker are registered from the next position so
   // they line up with the counters without extra delay.
   assign fetch_d = (h_d < 10'(H_ACTIVE)) && (v_d < 10'(V_ACTIVE)) && (h_d[2:0] == 3'd0);
   assign addr_d  = BASE_ADDR + 16'(v_d[9:3]) * 16'(COLS) + 16'(h_d[9:3]);

   // Counters and the FETCH stage; mem_addr holds its last value between reads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q         <= 1'b0;
         h_q           <= '0;
         v_q           <= '0;
         mem_rd_en_q   <= 1'b0;
         frame_start_q <= 1'b0;
         mem_addr_q    <= BASE_ADDR;
      end else begin
         run_q         <= 1'b1;
         h_q           <= h_d;
         v_q           <= v_d;
         mem_rd_en_q   <= fetch_d;
         frame_start_q <= (h_d == 10'd0) && (v_d == 10'd0);
         if (fetch_d) begin
            mem_addr_q <= addr_d;
         end
      end
   end

   // FONT stage: capture cell attributes as the read data arrives.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_p1_q  <= 1'b0;
         act_p1_q <= 1'b0;
         hs_p1_q  <= 1'b0;
         vs_p1_q  <= 1'b0;
         hlo_p1_q <= '0;
         vlo_p1_q <= '0;
         fg_q     <= '0;
         bg_q     <= '0;
      end else begin
         rd_p1_q  <= mem_rd_en_q;
         act_p1_q <= act0;
         hs_p1_q  <= hs0;
         vs_p1_q  <= vs0;
         hlo_p1_q <= h_q[2:0];
         vlo_p1_q <= v_q[2:0];
         if (rd_p1_q) begin
            fg_q <= mem_rd_data[10:8];
            bg_q <= mem_rd_data[14:12];
         end
      end
   end

   text_font_rom u_font (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .en_i   (rd_p1_q),
      .addr_i ({mem_rd_data[7:0], vlo_p1_q}),
      .data_o (rom_dout)
   );

   // SHIFT stage: latch the glyph row on the cell's first pixel.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act_p2_q <= 1'b0;
         hs_p2_q  <= 1'b0;
         vs_p2_q  <= 1'b0;
         hlo_p2_q <= '0;
         row_q    <= '0;
      end else begin
         act_p2_q <= act_p1_q;
         hs_p2_q  <= hs_p1_q;
         vs_p2_q  <= vs_p1_q;
         hlo_p2_q <= hlo_p1_q;
         if (hlo_p2_q == 3'd0) begin
            row_q <= rom_dout;
         end
      end
   end

   // The first pixel of a cell comes straight from the ROM, the rest from row_q.
   assign row_sel = (hlo_p2_q == 3'd0) ? rom_dout : row_q;
   assign pix     = row_sel[3'd7 - hlo_p2_q];

`ifdef TEXT_SCANOUT_BLINK_EN
   logic       blink_q;
   logic [5:0] frame_cnt_q;

   // Blink attribute per cell and a free-running frame count (32 on, 32 off).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blink_q     <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         if (rd_p1_q) begin
            blink_q <= mem_rd_data[15];
         end
         if (frame_start_q) begin
            frame_cnt_q <= frame_cnt_q + 6'd1;
         end
      end
   end

   assign fg_eff = (blink_q && frame_cnt_q[5]) ? bg_q : fg_q;
`else
   assign fg_eff = fg_q;
`endif

   // Output registers; colour forced to black outside the active area.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         de_q    <= 1'b0;
         hsync_q <= 1'b1;
         vsync_q <= 1'b1;
         rgb_q   <= '0;
      end else begin
         de_q    <= act_p2_q;
         hsync_q <= ~hs_p2_q;
         vsync_q <= ~vs_p2_q;
         rgb_q   <= act_p2_q ? (pix ? fg_eff : bg_q) : 3'b000;
      end
   end

   // Bit 11 is reserved and bit 15 is only consumed by the blink option.
   assign unused_bits = ^{mem_rd_data[15], mem_rd_data[11]};

   assign mem_addr    = mem_addr_q;
   assign mem_rd_en   = mem_rd_en_q;
   assign frame_start = frame_start_q;
   assign de          = de_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign rgb         = rgb_q;

endmodule
